friscv_dcache_blocks: RTL and testbench

Direct-mapped data-cache storage that sits directly downstream of the dCache write pusher and beside the dCache fetcher. It answers the pusher's hit/miss probe with a one-cycle latency and applies the pusher's byte-strobed block updates. It serves fetcher lookups and accepts full-line fills from the fetcher. It also runs a multi-cycle flush that invalidates every line.

---
 rtl/friscv_dcache_blocks.sv | 229 ++++++++++++++++++++++
 tb/tb_friscv_dcache_blocks.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_dcache_blocks.sv
// Direct-mapped data-cache storage: tag/data arrays with flop valid bits,
// a registered hit/miss probe for the write pusher, a registered lookup for
// the fetcher, full-line fills, byte-strobed pusher updates and a flush FSM
// that walks every line clearing its valid bit.
module friscv_dcache_blocks #(
  parameter     NAME          = "dcache-blocks",
  parameter int XLEN          = 32,
  parameter int AXI_ADDR_W    = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 64
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic                       srst,
  input  logic                       flush_req,
  output logic                       flush_ack,
  output logic                       flush_busy,
  input  logic                       p_ren,
  input  logic [AXI_ADDR_W-1:0]      p_raddr,
  output logic                       p_hit,
  output logic                       p_miss,
  input  logic                       p_wen,
  input  logic [AXI_ADDR_W-1:0]      p_waddr,
  input  logic [CACHE_BLOCK_W-1:0]   p_wdata,
  input  logic [CACHE_BLOCK_W/8-1:0] p_wstrb,
  input  logic                       f_ren,
  input  logic [AXI_ADDR_W-1:0]      f_raddr,
  output logic [CACHE_BLOCK_W-1:0]   f_rdata,
  output logic                       f_hit,
  output logic                       f_miss,
  input  logic                       fill_wen,
  input  logic [AXI_ADDR_W-1:0]      fill_addr,
  input  logic [CACHE_BLOCK_W-1:0]   fill_wdata
);

  localparam int STRB_W = CACHE_BLOCK_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(CACHE_DEPTH);
  localparam int TAG_W  = AXI_ADDR_W - OFF_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CACHE_DEPTH - 1);

  // Tracer name and architecture width carry no logic in this block.
  localparam     unused_name = NAME;
  localparam int unused_xlen = XLEN;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ACK
  } flush_state_t;

  flush_state_t state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [CACHE_DEPTH-1:0] valid_q, valid_d;

  logic [CACHE_BLOCK_W-1:0] data_q [CACHE_DEPTH];
  logic [TAG_W-1:0]         tag_q  [CACHE_DEPTH];

  logic                     p_hit_q, p_hit_d, p_miss_q, p_miss_d;
  logic                     f_hit_q, f_hit_d, f_miss_q, f_miss_d;
  logic [CACHE_BLOCK_W-1:0] f_rdata_q, f_rdata_d;

  logic [IDX_W-1:0] p_r_idx, p_w_idx, f_r_idx, fill_idx;
  logic [TAG_W-1:0] p_r_tag, p_w_tag, f_r_tag, fill_tag;

  logic                     busy;
  logic                     fill_go, pw_go, same_w_idx, fill_merge, p_cur_hit;
  logic [CACHE_BLOCK_W-1:0] fill_line, pw_line;

  logic                     p_view_valid, f_view_valid;
  logic [TAG_W-1:0]         p_view_tag, f_view_tag;
  logic [CACHE_BLOCK_W-1:0] f_view_data;
  logic                     p_lookup_hit, f_lookup_hit;

  logic unused_offsets;
  assign unused_offsets = ^{p_raddr[OFF_W-1:0], p_waddr[OFF_W-1:0],
                            f_raddr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

  assign p_r_idx  = p_raddr[OFF_W +: IDX_W];
  assign p_w_idx  = p_waddr[OFF_W +: IDX_W];
  assign f_r_idx  = f_raddr[OFF_W +: IDX_W];
  assign fill_idx = fill_addr[OFF_W +: IDX_W];
  assign p_r_tag  = p_raddr[AXI_ADDR_W-1 -: TAG_W];
  assign p_w_tag  = p_waddr[AXI_ADDR_W-1 -: TAG_W];
  assign f_r_tag  = f_raddr[AXI_ADDR_W-1 -: TAG_W];
  assign fill_tag = fill_addr[AXI_ADDR_W-1 -: TAG_W];

  assign busy       = (state_q != ST_IDLE);
  assign flush_busy = busy;
  assign flush_ack  = (state_q == ST_ACK);

  assign p_hit   = p_hit_q;
  assign p_miss  = p_miss_q;
  assign f_hit   = f_hit_q;
  assign f_miss  = f_miss_q;
  assign f_rdata = f_rdata_q;

  function automatic logic [CACHE_BLOCK_W-1:0] merge_bytes(
    input logic [CACHE_BLOCK_W-1:0] base,
    input logic [CACHE_BLOCK_W-1:0] upd,
    input logic [STRB_W-1:0]        strb
  );
    logic [CACHE_BLOCK_W-1:0] res;
    res = base;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = upd[i*8 +: 8];
    end
    return res;
  endfunction

  // Decide which writes land this cycle: a fill wins its index and absorbs a
  // same-tag pusher update; otherwise the pusher writes only on a current hit.
  always_comb begin
    fill_go    = fill_wen && !busy;
    same_w_idx = (p_w_idx == fill_idx);
    p_cur_hit  = valid_q[p_w_idx] && (tag_q[p_w_idx] == p_w_tag);
    fill_merge = p_wen && same_w_idx && (p_w_tag == fill_tag);
    fill_line  = fill_merge ? merge_bytes(fill_wdata, p_wdata, p_wstrb) : fill_wdata;
    pw_go      = p_wen && !busy && p_cur_hit && !(fill_go && same_w_idx);
    pw_line    = merge_bytes(data_q[p_w_idx], p_wdata, p_wstrb);
  end

  // Write-first view of the addressed lines so that a request colliding with
  // a write in the same cycle observes the post-write valid, tag and data.
  always_comb begin
    p_view_valid = valid_q[p_r_idx];
    p_view_tag   = tag_q[p_r_idx];
    if (fill_go && (p_r_idx == fill_idx)) begin
      p_view_valid = 1'b1;
      p_view_tag   = fill_tag;
    end
    f_view_valid = valid_q[f_r_idx];
    f_view_tag   = tag_q[f_r_idx];
    f_view_data  = data_q[f_r_idx];
    if (pw_go && (f_r_idx == p_w_idx)) begin
      f_view_data = pw_line;
    end
    if (fill_go && (f_r_idx == fill_idx)) begin
      f_view_valid = 1'b1;
      f_view_tag   = fill_tag;
      f_view_data  = fill_line;
    end
    p_lookup_hit = !busy && p_view_valid && (p_view_tag == p_r_tag);
    f_lookup_hit = !busy && f_view_valid && (f_view_tag == f_r_tag);
  end

  // Next values of the registered probe and lookup results.
  always_comb begin
    p_hit_d   = p_ren && p_lookup_hit;
    p_miss_d  = p_ren && !p_lookup_hit;
    f_hit_d   = f_ren && f_lookup_hit;
    f_miss_d  = f_ren && !f_lookup_hit;
    f_rdata_d = f_hit_d ? f_view_data : f_rdata_q;
    if (srst) begin
      p_hit_d   = 1'b0;
      p_miss_d  = 1'b0;
      f_hit_d   = 1'b0;
      f_miss_d  = 1'b0;
      f_rdata_d = '0;
    end
  end

  // Flush sequencing plus valid-bit maintenance (fill sets, flush clears).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (fill_go) valid_d[fill_idx] = 1'b1;
    if (srst) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = '0;
    end
  end

  // Control and output registers, cleared by the asynchronous reset.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      p_hit_q   <= 1'b0;
      p_miss_q  <= 1'b0;
      f_hit_q   <= 1'b0;
      f_miss_q  <= 1'b0;
      f_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      p_hit_q   <= p_hit_d;
      p_miss_q  <= p_miss_d;
      f_hit_q   <= f_hit_d;
      f_miss_q  <= f_miss_d;
      f_rdata_q <= f_rdata_d;
    end
  end

  // Tag and data storage; contents are only meaningful behind a valid bit.
  always_ff @(posedge aclk) begin
    if (fill_go) begin
      data_q[fill_idx] <= fill_line;
      tag_q[fill_idx]  <= fill_tag;
    end
    if (pw_go) begin
      data_q[p_w_idx] <= pw_line;
    end
  end

endmodule

// File: tb/tb_friscv_dcache_blocks.sv
// Self-checking bench for friscv_dcache_blocks: directed scenarios followed
// by randomized traffic compared against a line-level cache model.
module tb_friscv_dcache_blocks;

  localparam int DEPTH = 64;

  logic         aclk = 1'b0;
  logic         arst, srst, flush_req;
  logic         flush_ack, flush_busy;
  logic         p_ren, p_hit, p_miss, p_wen;
  logic [31:0]  p_raddr, p_waddr;
  logic [127:0] p_wdata;
  logic [15:0]  p_wstrb;
  logic         f_ren, f_hit, f_miss;
  logic [31:0]  f_raddr;
  logic [127:0] f_rdata;
  logic         fill_wen;
  logic [31:0]  fill_addr;
  logic [127:0] fill_wdata;

  int checks = 0;
  int fails  = 0;

  // Reference model: one entry per line plus a countdown of busy cycles.
  bit           m_valid [DEPTH];
  logic [21:0]  m_tag   [DEPTH];
  logic [127:0] m_data  [DEPTH];
  int           m_flush_left;
  logic         e_p_hit, e_p_miss, e_f_hit, e_f_miss, e_busy, e_ack;
  logic [127:0] e_rdata;

  friscv_dcache_blocks dut (
    .aclk       (aclk),
    .arst       (arst),
    .srst       (srst),
    .flush_req  (flush_req),
    .flush_ack  (flush_ack),
    .flush_busy (flush_busy),
    .p_ren      (p_ren),
    .p_raddr    (p_raddr),
    .p_hit      (p_hit),
    .p_miss     (p_miss),
    .p_wen      (p_wen),
    .p_waddr    (p_waddr),
    .p_wdata    (p_wdata),
    .p_wstrb    (p_wstrb),
    .f_ren      (f_ren),
    .f_raddr    (f_raddr),
    .f_rdata    (f_rdata),
    .f_hit      (f_hit),
    .f_miss     (f_miss),
    .fill_wen   (fill_wen),
    .fill_addr  (fill_addr),
    .fill_wdata (fill_wdata)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mergeLine(input logic [127:0] base, input logic [127:0] upd,
                                             input logic [15:0] strb);
    logic [127:0] r;
    r = base;
    for (int b = 0; b < 16; b++) if (strb[b]) r[b*8 +: 8] = upd[b*8 +: 8];
    return r;
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    return int'((a >> 4) % DEPTH);
  endfunction

  function automatic logic [21:0] tagOf(input logic [31:0] a);
    return 22'(a >> 10);
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    return m_valid[idxOf(a)] && (m_tag[idxOf(a)] == tagOf(a));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_flush_left = 0;
    e_p_hit = 0; e_p_miss = 0; e_f_hit = 0; e_f_miss = 0;
    e_busy = 0; e_ack = 0; e_rdata = '0;
  endtask

  // Model the effect of the coming clock edge on the cache and its outputs.
  task automatic modelEdge();
    bit b, phit_pre;
    int pi, fi;
    logic [127:0] line;
    b = (m_flush_left > 0);
    if (srst) begin
      modelReset();
      return;
    end
    if (!b) begin
      pi = idxOf(p_waddr);
      fi = idxOf(fill_addr);
      phit_pre = modelHit(p_waddr);
      if (fill_wen) begin
        line = fill_wdata;
        if (p_wen && pi == fi && tagOf(p_waddr) == tagOf(fill_addr))
          line = mergeLine(line, p_wdata, p_wstrb);
        m_data[fi] = line;
        m_tag[fi] = tagOf(fill_addr);
        m_valid[fi] = 1'b1;
      end
      if (p_wen && phit_pre && !(fill_wen && pi == fi))
        m_data[pi] = mergeLine(m_data[pi], p_wdata, p_wstrb);
    end
    e_p_hit  = p_ren && !b && modelHit(p_raddr);
    e_p_miss = p_ren && !e_p_hit;
    e_f_hit  = f_ren && !b && modelHit(f_raddr);
    e_f_miss = f_ren && !e_f_hit;
    if (e_f_hit) e_rdata = m_data[idxOf(f_raddr)];
    if (b) m_flush_left--;
    else if (flush_req) begin
      m_flush_left = DEPTH + 1;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end
    e_busy = (m_flush_left > 0);
    e_ack  = (m_flush_left == 1);
  endtask

  task automatic sampleOutputs();
    checkOutput("p_hit", p_hit, e_p_hit);
    checkOutput("p_miss", p_miss, e_p_miss);
    checkOutput("f_hit", f_hit, e_f_hit);
    checkOutput("f_miss", f_miss, e_f_miss);
    checkOutput("f_rdata", f_rdata, e_rdata);
    checkOutput("flush_busy", flush_busy, e_busy);
    checkOutput("flush_ack", flush_ack, e_ack);
  endtask

  // One clock: predict, let the edge pass, compare at the falling edge.
  task automatic applyStimulus();
    modelEdge();
    @(negedge aclk);
    sampleOutputs();
  endtask

  task automatic clearInputs();
    srst = 0; flush_req = 0; p_ren = 0; p_wen = 0; f_ren = 0; fill_wen = 0;
    p_wstrb = '0;
  endtask

  function automatic logic [31:0] randAddr();
    logic [21:0] t;
    logic [5:0]  i;
    logic [3:0]  o;
    t = 22'($urandom_range(1, 2));
    i = 6'($urandom_range(0, 3));
    o = 4'($urandom);
    return {t, i, o};
  endfunction

  function automatic logic [127:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic lookup(input logic [31:0] a);
    f_ren = 1; f_raddr = a;
    applyStimulus();
    f_ren = 0;
  endtask

  // Run a flush from a single request and measure busy/ack lengths.
  task automatic runFlush(input string tag);
    int busy_cnt, ack_cnt;
    busy_cnt = 0; ack_cnt = 0;
    flush_req = 1;
    applyStimulus();
    flush_req = 0;
    for (int i = 0; i < 100; i++) begin
      if (flush_busy) busy_cnt++;
      if (flush_ack) ack_cnt++;
      if (!flush_busy) break;
      if (i == 10) checkOutput({tag, "_lookup_miss"}, f_miss, 1'b1);
      f_ren = (i == 9); f_raddr = 32'h0000_1230;
      applyStimulus();
      f_ren = 0;
    end
    checkOutput({tag, "_busy_len"}, 128'(busy_cnt), 128'(DEPTH + 1));
    checkOutput({tag, "_ack_len"}, 128'(ack_cnt), 128'd1);
  endtask

  initial begin
    arst = 1;
    clearInputs();
    p_raddr = '0; p_waddr = '0; f_raddr = '0; fill_addr = '0;
    p_wdata = '0; fill_wdata = '0;
    modelReset();
    repeat (2) begin
      @(negedge aclk);
      sampleOutputs();
    end
    arst = 0;

    // Fill then lookup with a different offset in the same line.
    fill_wen = 1; fill_addr = 32'h0000_1230;
    fill_wdata = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    applyStimulus();
    fill_wen = 0;
    lookup(32'h0000_123C);
    checkOutput("tp_fill_hit", f_hit, 1'b1);
    checkOutput("tp_fill_data", f_rdata, 128'h0000_0004_0000_0003_0000_0002_0000_0001);

    // Probe hit and same-index different-tag miss.
    p_ren = 1; p_raddr = 32'h0000_1234;
    applyStimulus();
    checkOutput("tp_probe_hit", p_hit, 1'b1);
    p_raddr = 32'h0000_2234;
    applyStimulus();
    checkOutput("tp_probe_miss", p_miss, 1'b1);
    p_ren = 0;

    // Strobed pusher write on hit, then the same write on a miss.
    p_wen = 1; p_waddr = 32'h0000_1230; p_wstrb = 16'h00F0;
    p_wdata = {4{32'hDEAD_BEEF}};
    applyStimulus();
    p_wen = 0;
    lookup(32'h0000_1230);
    checkOutput("tp_pwrite_hit", f_rdata, 128'h0000_0004_0000_0003_DEAD_BEEF_0000_0001);
    p_wen = 1; p_waddr = 32'h0000_2230;
    p_wdata = {4{32'h1234_5678}};
    applyStimulus();
    p_wen = 0;
    lookup(32'h0000_1230);
    checkOutput("tp_pwrite_miss", f_rdata, 128'h0000_0004_0000_0003_DEAD_BEEF_0000_0001);

    // Fill and pusher write colliding on one index.
    fill_wen = 1; fill_addr = 32'h0000_0400; fill_wdata = '0;
    p_wen = 1; p_waddr = 32'h0000_0400; p_wstrb = 16'h000F; p_wdata = {4{32'hFFFF_FFFF}};
    applyStimulus();
    fill_wen = 0; p_wen = 0;
    lookup(32'h0000_0400);
    checkOutput("tp_merge_same_tag", f_rdata, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    fill_wen = 1; p_wen = 1; p_waddr = 32'h0000_0800;
    applyStimulus();
    fill_wen = 0; p_wen = 0;
    lookup(32'h0000_0400);
    checkOutput("tp_merge_diff_tag", f_rdata, 128'h0);

    // Flush with three filled lines; every former hit must now miss.
    fill_wen = 1; fill_addr = 32'h0000_5670; fill_wdata = randLine();
    applyStimulus();
    fill_wen = 0;
    runFlush("flush1");
    lookup(32'h0000_1230);
    checkOutput("post_flush_a", f_miss, 1'b1);
    lookup(32'h0000_0400);
    checkOutput("post_flush_b", f_miss, 1'b1);
    lookup(32'h0000_5670);
    checkOutput("post_flush_c", f_miss, 1'b1);

    // Asynchronous reset in the middle of a flush.
    fill_wen = 1; fill_addr = 32'h0000_1230; fill_wdata = randLine();
    applyStimulus();
    fill_wen = 0;
    lookup(32'h0000_1230);
    flush_req = 1;
    applyStimulus();
    flush_req = 0;
    repeat (29) applyStimulus();
    arst = 1;
    #1;
    modelReset();
    checkOutput("arst_busy", flush_busy, 1'b0);
    checkOutput("arst_ack", flush_ack, 1'b0);
    checkOutput("arst_f_rdata", f_rdata, 128'h0);
    checkOutput("arst_hits", {p_hit, p_miss, f_hit, f_miss}, 4'b0);
    #1 arst = 0;
    repeat (3) applyStimulus();
    runFlush("flush2");

    // Synchronous reset clears lines like the asynchronous one.
    fill_wen = 1; fill_addr = 32'h0000_1230; fill_wdata = randLine();
    applyStimulus();
    fill_wen = 0;
    srst = 1;
    applyStimulus();
    srst = 0;
    lookup(32'h0000_1230);
    checkOutput("srst_miss", f_miss, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      p_ren = 1'($urandom); p_raddr = randAddr();
      p_wen = ($urandom_range(0, 2) == 0); p_waddr = randAddr();
      p_wdata = randLine(); p_wstrb = 16'($urandom);
      f_ren = 1'($urandom); f_raddr = randAddr();
      fill_wen = ($urandom_range(0, 3) == 0); fill_addr = randAddr(); fill_wdata = randLine();
      flush_req = ($urandom_range(0, 199) == 0);
      srst = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end
    clearInputs();
    applyStimulus();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
